// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, operand forwarding and multi-cycle EX hold for a 5-stage in-order
// pipeline. EX/MEM/WB shadow slots mirror the decoded ops travelling down the datapath.
module pipe_hazard_ctrl #(
    parameter int AW      = 5,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,

    input  logic             id_valid_i,
    input  logic [AW-1:0]    id_rs1_i,
    input  logic [AW-1:0]    id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic [AW-1:0]    id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             id_multi_i,
    input  logic             id_branch_i,
    input  logic             id_taken_i,

    output logic             stall_o,
    output logic             bubble_o,
    output logic             flush_o,
    output logic             ex_hold_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             fwd_br_a_o,
    output logic             fwd_br_b_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int MC_W = 4;
    localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MUL_LAT - 1);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          use_rs1;
        logic          use_rs2;
        logic [AW-1:0] rd;
        logic          regwrite;
        logic          memread;
        logic          multi;
    } slot_t;

    slot_t             ex_q, ex_d;
    slot_t             mem_q, mem_d;
    slot_t             wb_q, wb_d;
    slot_t             id_slot;
    logic [MC_W-1:0]   mc_q, mc_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              load_use;
    logic              br_hazard;
    logic              hazard;

    // x0 is hard-wired zero, so a write to it never produces a dependency.
    function automatic logic slot_match(input slot_t s, input logic [AW-1:0] src,
                                        input logic use_src);
        return s.valid && s.regwrite && (s.rd == src) && (src != '0) && use_src;
    endfunction

    function automatic logic [1:0] ex_fwd_sel(input slot_t m, input slot_t w,
                                              input logic [AW-1:0] src, input logic use_src);
        logic [1:0] sel;
        sel = 2'b00;
        if (slot_match(m, src, use_src) && !m.memread) begin
            sel = 2'b10;
        end else if (slot_match(w, src, use_src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        id_slot          = '0;
        id_slot.valid    = id_valid_i;
        id_slot.rs1      = id_rs1_i;
        id_slot.rs2      = id_rs2_i;
        id_slot.use_rs1  = id_use_rs1_i;
        id_slot.use_rs2  = id_use_rs2_i;
        id_slot.rd       = id_rd_i;
        id_slot.regwrite = id_regwrite_i;
        id_slot.memread  = id_memread_i;
        id_slot.multi    = id_multi_i;
    end

    always_comb begin
        ex_hold_o = (mc_q != '0);

        load_use = id_valid_i && ex_q.memread &&
                   (slot_match(ex_q, id_rs1_i, id_use_rs1_i) ||
                    slot_match(ex_q, id_rs2_i, id_use_rs2_i));

        // The ID-stage comparator cannot take a load result from MEM, nor anything from EX.
        br_hazard = id_valid_i && id_branch_i &&
                    (slot_match(ex_q, id_rs1_i, id_use_rs1_i) ||
                     slot_match(ex_q, id_rs2_i, id_use_rs2_i) ||
                     (mem_q.memread &&
                      (slot_match(mem_q, id_rs1_i, id_use_rs1_i) ||
                       slot_match(mem_q, id_rs2_i, id_use_rs2_i))));

        hazard   = load_use || br_hazard;
        stall_o  = hazard || ex_hold_o;
        bubble_o = hazard && !ex_hold_o;
        flush_o  = id_valid_i && id_branch_i && id_taken_i && !stall_o;

        fwd_a_o = ex_fwd_sel(mem_q, wb_q, ex_q.rs1, ex_q.use_rs1);
        fwd_b_o = ex_fwd_sel(mem_q, wb_q, ex_q.rs2, ex_q.use_rs2);

        fwd_br_a_o = id_valid_i && id_branch_i && !mem_q.memread &&
                     slot_match(mem_q, id_rs1_i, id_use_rs1_i);
        fwd_br_b_o = id_valid_i && id_branch_i && !mem_q.memread &&
                     slot_match(mem_q, id_rs2_i, id_use_rs2_i);
    end

    always_comb begin
        ex_d  = '0;
        mem_d = '0;
        wb_d  = mem_q;
        mc_d  = mc_q;
        if (ex_hold_o) begin
            ex_d = ex_q;
            mc_d = mc_q - MC_W'(1);
        end else begin
            mem_d = ex_q;
            if (id_valid_i && !bubble_o) begin
                ex_d = id_slot;
                if (id_multi_i) begin
                    mc_d = MC_LOAD;
                end
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            mc_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            mc_q        <= mc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule
